vreg_file_param: RTL and testbench
==================================

# vreg_file_param

Parametrised vector register file for the ID stage: NREGS registers of VLEN bits, two asynchronous read ports, one write port with per-lane write mask. Optional same-cycle write-to-read bypass. A sequential bulk-clear engine zeroes the file one register per cycle under a busy/done handshake. Successor to the fixed 3×256 vector register file; it feeds the vector execute stage through bus_a and bus_b.

## Interface
- NREGS, 4, number of vector registers (≥2)
- VLEN, 256, register width in bits
- LANE_W, 32, lane width; VLEN must be a multiple of LANE_W; NLANES = VLEN/LANE_W
- BYPASS, 1, 1 = write data forwarded to same-cycle reads of rw; 0 = reads see stored contents only
- AW, $clog2(NREGS) (min 1), address width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ra  in  AW  read address A
- rb  in  AW  read address B
- rw  in  AW  write address
- reg_write  in  1  write enable
- wmask  in  NLANES  per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W]
- bus_w  in  VLEN  write data
- bus_a  out  VLEN  read data A
- bus_b  out  VLEN  read data B
- clear_req  in  1  start bulk clear (level-sampled in IDLE)
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse when clear completes
- addr_err  out  1  sticky: any write or read with address ≥ NREGS

## Operation
- Write: at a rising edge with reg_write=1, clear_busy=0, rw<NREGS → reg[rw] lanes with wmask[i]=1 take bus_w lanes; other lanes unchanged. wmask=0 is a no-op.
- Write while clear_busy=1 → dropped silently; caller must gate on clear_busy.
- Read: bus_a = reg[ra], bus_b = reg[rb], combinational. Address ≥ NREGS → output all zero.
- Bypass (BYPASS=1): if a write is accepted this cycle and ra==rw, bus_a = merged value (bus_w lanes where wmask=1, stored lanes elsewhere). Same for rb. BYPASS=0 → stored value.
- addr_err: set at the edge where reg_write=1 with rw≥NREGS, or ra/rb≥NREGS. Cleared only by reset. Cannot fire when NREGS is a power of two.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE → CLEAR when clear_req=1; idx←0.
  - CLEAR: each edge, reg[idx]←0 and idx++. After clearing idx=NREGS-1 → DONE.
  - DONE → IDLE unconditionally.
- clear_busy = (state==CLEAR). clear_done = (state==DONE).
- clear_req in CLEAR or DONE is ignored. clear_req still high in IDLE after DONE starts a new clear.
- Reads during CLEAR return current contents, partially zeroed. Bypass never applies because writes are blocked.

## Timing
- Reset (reset_n=0, async): all registers 0, state IDLE, idx 0, addr_err 0. Outputs during reset: clear_busy=0, clear_done=0, bus_a=bus_b=0.
- Reset mid-clear: immediate return to IDLE, all registers zero, no clear_done pulse.
- Write latency: 1 edge to storage; 0 cycles to reads with BYPASS=1.
- Clear: clear_req sampled at edge k → clear_busy high for cycles k..k+NREGS-1 (edges k+1..k+NREGS clear reg[0..NREGS-1]) → clear_done high for exactly one cycle after edge k+NREGS → IDLE after edge k+NREGS+1.
- A write accepted at edge k (the same edge clear_req is sampled, busy still 0) commits, then is zeroed by the clear.

## Structure
- Package vreg_pkg: clear-state enum (IDLE/CLEAR/DONE) and an NLANES helper function (VLEN/LANE_W).
- Sub-module vreg_lane_merge (old, new, mask → merged): pure combinational. Used once for the write path and reused for each bypass port.
- idx width AW; storage is a reg array [0:NREGS-1].

## Test plan
- Reset, then write rw=1, wmask=all-1, bus_w=0xA5…A5 → next cycle ra=1 gives 0xA5…A5; rb=0 gives 0.
- reg[2]=all-1; write rw=2, wmask=0b0000_0001, bus_w=0 → reg[2] = all-1 except bits[31:0]=0.
- BYPASS=1: same-cycle reg_write to rw=3 with bus_w=0x1234, ra=3 → bus_a shows merged value that cycle. BYPASS=0 → old value shown.
- Fill all 4 regs, pulse clear_req → busy for 4 cycles, one register zeroed per edge, done pulse on the 5th cycle. reg_write during busy has no effect.
- Assert reset_n=0 during cycle 2 of a clear → immediate IDLE, all regs 0, no clear_done.
- NREGS=3: write rw=3 → no storage change, addr_err=1 and stays 1. ra=3 → bus_a=0.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared types and helpers for the parametrised vector register file.
package vreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  function automatic int nlanes(input int vlen, input int lane_w);
    return vlen / lane_w;
  endfunction

endpackage

// File: rtl/vreg_lane_merge.sv
// Per-lane select between an existing vector and new data under a lane mask.
module vreg_lane_merge
  import vreg_pkg::*;
#(
  parameter int VLEN   = 256,
  parameter int LANE_W = 32,
  parameter int NLANES = nlanes(VLEN, LANE_W)
) (
  input  logic [VLEN-1:0]   old_v,
  input  logic [VLEN-1:0]   new_v,
  input  logic [NLANES-1:0] mask,
  output logic [VLEN-1:0]   merged
);

  // Lanes with mask set take new data, all others keep the old value.
  always_comb begin
    merged = old_v;
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i]) merged[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/vreg_file_param.sv
// Vector register file: two async read ports, one masked write port,
// optional write-to-read bypass and a one-register-per-cycle clear engine.
module vreg_file_param
  import vreg_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int VLEN   = 256,
  parameter int LANE_W = 32,
  parameter int BYPASS = 1,
  parameter int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [AW-1:0]                   ra,
  input  logic [AW-1:0]                   rb,
  input  logic [AW-1:0]                   rw,
  input  logic                            reg_write,
  input  logic [nlanes(VLEN, LANE_W)-1:0] wmask,
  input  logic [VLEN-1:0]                 bus_w,
  output logic [VLEN-1:0]                 bus_a,
  output logic [VLEN-1:0]                 bus_b,
  input  logic                            clear_req,
  output logic                            clear_busy,
  output logic                            clear_done,
  output logic                            addr_err
);

  localparam int NLANES = nlanes(VLEN, LANE_W);

  logic [VLEN-1:0] regs [0:NREGS-1];
  clr_state_t      state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;

  logic [VLEN-1:0] stored_a, stored_b, stored_w, merged_w;
  logic            we;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  assign clear_busy = (state == CLEAR);
  assign clear_done = (state == DONE);

  assign stored_a = in_range(ra) ? regs[ra] : '0;
  assign stored_b = in_range(rb) ? regs[rb] : '0;
  assign stored_w = in_range(rw) ? regs[rw] : '0;

  // Writes are refused while the clear engine owns the array.
  assign we = reg_write && !clear_busy && in_range(rw);

  vreg_lane_merge #(.VLEN(VLEN), .LANE_W(LANE_W), .NLANES(NLANES)) u_merge_w (
    .old_v  (stored_w),
    .new_v  (bus_w),
    .mask   (wmask),
    .merged (merged_w)
  );

  if (BYPASS != 0) begin : g_byp
    logic [NLANES-1:0] mask_a, mask_b;

    // An out-of-range read address can never match an accepted write.
    assign mask_a = (we && ra == rw) ? wmask : '0;
    assign mask_b = (we && rb == rw) ? wmask : '0;

    vreg_lane_merge #(.VLEN(VLEN), .LANE_W(LANE_W), .NLANES(NLANES)) u_merge_a (
      .old_v  (stored_a),
      .new_v  (bus_w),
      .mask   (mask_a),
      .merged (bus_a)
    );

    vreg_lane_merge #(.VLEN(VLEN), .LANE_W(LANE_W), .NLANES(NLANES)) u_merge_b (
      .old_v  (stored_b),
      .new_v  (bus_w),
      .mask   (mask_b),
      .merged (bus_b)
    );
  end else begin : g_nobyp
    assign bus_a = stored_a;
    assign bus_b = stored_b;
  end

  // Clear engine next-state: walk idx from 0 to NREGS-1, then pulse DONE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        idx_nxt = idx + AW'(1);
        if (32'(idx) == NREGS - 1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear engine state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Storage: clear engine zeroes one entry per edge, otherwise masked write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clear_busy) begin
      regs[idx] <= '0;
    end else if (we) begin
      regs[rw] <= merged_w;
    end
  end

  // Sticky flag for any out-of-range write or read address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if ((reg_write && !in_range(rw)) || !in_range(ra) || !in_range(rb)) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vreg_file_param.sv
// Bench for vreg_file_param: a default instance (4 regs, bypass on) and a
// 3-register instance without bypass share one randomized stimulus stream.
module tb_vreg_file_param;

  logic         clk;
  logic         reset_n;
  logic [1:0]   ra, rb, rw;
  logic         reg_write;
  logic [7:0]   wmask;
  logic [255:0] bus_w;
  logic         clear_req;
  logic [255:0] bus_a0, bus_b0, bus_a1, bus_b1;
  logic         busy0, done0, err0, busy1, done1, err1;

  int total = 0;
  int bad   = 0;

  vreg_file_param #(.NREGS(4), .VLEN(256), .LANE_W(32), .BYPASS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rb(rb), .rw(rw),
    .reg_write(reg_write), .wmask(wmask), .bus_w(bus_w),
    .bus_a(bus_a0), .bus_b(bus_b0), .clear_req(clear_req),
    .clear_busy(busy0), .clear_done(done0), .addr_err(err0)
  );

  vreg_file_param #(.NREGS(3), .VLEN(256), .LANE_W(32), .BYPASS(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rb(rb), .rw(rw),
    .reg_write(reg_write), .wmask(wmask), .bus_w(bus_w),
    .bus_a(bus_a1), .bus_b(bus_b1), .clear_req(clear_req),
    .clear_busy(busy1), .clear_done(done1), .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents per instance, clear described by the edge
  // number k at which the request was taken (busy cycles k..k+N-1,
  // done in cycle k+N, edge k+j zeroes register j-1).
  logic [255:0] mem [2][4];
  int           nr  [2] = '{4, 3};
  bit           byp [2] = '{1'b1, 1'b0};
  bit           act [2];
  int           k   [2];
  bit           err [2];
  int           e;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] merge(input logic [255:0] old_v, input logic [255:0] nv,
                                         input logic [7:0] m);
    logic [255:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*32 +: 32] = nv[i*32 +: 32];
    return r;
  endfunction

  function automatic bit m_busy(input int d, input int c);
    return act[d] && c >= k[d] && c <= k[d] + nr[d] - 1;
  endfunction

  function automatic bit m_done(input int d, input int c);
    return act[d] && c == k[d] + nr[d];
  endfunction

  function automatic bit m_idle(input int d, input int c);
    return !act[d] || c > k[d] + nr[d];
  endfunction

  function automatic logic [255:0] m_read(input int d, input int a);
    logic [255:0] v;
    if (a >= nr[d]) return '0;
    v = mem[d][a];
    if (byp[d] && reset_n && reg_write && !m_busy(d, e) && int'(rw) < nr[d] && int'(rw) == a)
      v = merge(v, bus_w, wmask);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 4; r++) mem[d][r] = '0;
      act[d] = 1'b0;
      k[d]   = 0;
      err[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    int c;
    int en;
    c  = e;
    en = e + 1;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit busy;
        bit idle;
        busy = m_busy(d, c);
        idle = m_idle(d, c);
        if (busy) mem[d][en - k[d] - 1] = '0;
        else if (reg_write && int'(rw) < nr[d]) mem[d][rw] = merge(mem[d][rw], bus_w, wmask);
        if ((reg_write && int'(rw) >= nr[d]) || int'(ra) >= nr[d] || int'(rb) >= nr[d])
          err[d] = 1'b1;
        if (idle && clear_req) begin
          act[d] = 1'b1;
          k[d]   = en;
        end
      end
    end
    e = en;
  endtask

  task automatic check_outputs();
    chk("bus_a0", bus_a0, m_read(0, int'(ra)));
    chk("bus_b0", bus_b0, m_read(0, int'(rb)));
    chk("bus_a1", bus_a1, m_read(1, int'(ra)));
    chk("bus_b1", bus_b1, m_read(1, int'(rb)));
    chk("busy0", {255'd0, busy0}, {255'd0, m_busy(0, e)});
    chk("done0", {255'd0, done0}, {255'd0, m_done(0, e)});
    chk("busy1", {255'd0, busy1}, {255'd0, m_busy(1, e)});
    chk("done1", {255'd0, done1}, {255'd0, m_done(1, e)});
    chk("err0",  {255'd0, err0},  {255'd0, err[0]});
    chk("err1",  {255'd0, err1},  {255'd0, err[1]});
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [7:0] m, input logic [255:0] d);
    reg_write = 1'b1;
    rw        = a;
    wmask     = m;
    bus_w     = d;
    cycle();
    reg_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nd;
    int done_at;
    logic [255:0] ones;
    ones = '1;

    reset_n = 1'b0; ra = '0; rb = '0; rw = '0; reg_write = 1'b0;
    wmask = '0; bus_w = '0; clear_req = 1'b0;
    e = 0;
    model_reset();
    cycle();
    cycle();
    reset_n = 1'b1;

    // full write then read back
    wr(2'd1, 8'hFF, {8{32'hA5A5A5A5}});
    ra = 2'd1; rb = 2'd0; #1;
    chk("a5_rd_a0", bus_a0, {8{32'hA5A5A5A5}});
    chk("a5_rd_b0", bus_b0, '0);
    chk("a5_rd_a1", bus_a1, {8{32'hA5A5A5A5}});
    cycle();

    // single-lane masked write
    wr(2'd2, 8'hFF, ones);
    wr(2'd2, 8'h01, '0);
    ra = 2'd2; #1;
    chk("mask_lane0", bus_a0, {{224{1'b1}}, 32'h0});

    // same-cycle bypass vs. stored value
    reg_write = 1'b1; rw = 2'd2; wmask = 8'h01; bus_w = 256'h1234; #1;
    chk("byp_on",  bus_a0, {{224{1'b1}}, 32'h1234});
    chk("byp_off", bus_a1, {{224{1'b1}}, 32'h0});
    cycle();
    reg_write = 1'b0; #1;
    chk("byp_commit", bus_a1, {{224{1'b1}}, 32'h1234});

    // bulk clear with writes attempted while busy
    for (int r = 0; r < 4; r++) wr(2'(r), 8'hFF, rnd256());
    ra = 2'd0; rb = 2'd1;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    nb = 0; nd = 0; done_at = -1;
    for (int j = 0; j < 6; j++) begin
      reg_write = busy0; rw = 2'd0; wmask = 8'hFF; bus_w = ones;
      if (busy0) nb++;
      if (done0) begin
        nd++;
        if (done_at < 0) done_at = j;
      end
      cycle();
    end
    reg_write = 1'b0;
    chk("clr_busy_cycles", 256'(nb), 256'd4);
    chk("clr_done_pulses", 256'(nd), 256'd1);
    chk("clr_done_at", 256'(done_at), 256'd4);
    ra = 2'd0; rb = 2'd3; #1;
    chk("clr_reg0", bus_a0, '0);
    chk("clr_reg3", bus_b0, '0);

    // async reset in the middle of a clear
    for (int r = 0; r < 4; r++) wr(2'(r), 8'hFF, rnd256());
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    cycle();
    ra = 2'd3; rb = 2'd1;
    reset_n = 1'b0; #1;
    chk("rst_busy", {255'd0, busy0}, '0);
    chk("rst_done", {255'd0, done0}, '0);
    chk("rst_bus_a", bus_a0, '0);
    chk("rst_bus_b", bus_b0, '0);
    model_reset();
    cycle();
    ra = 2'd0; rb = 2'd0;
    reset_n = 1'b1;
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      if (done0) nd++;
      cycle();
    end
    chk("rst_no_done", 256'(nd), 256'd0);

    // out-of-range access on the 3-register instance
    chk("err1_clean", {255'd0, err1}, '0);
    ra = 2'd3; #1;
    chk("oob_read", bus_a1, '0);
    wr(2'd3, 8'hFF, rnd256());
    ra = 2'd0;
    cycle();
    cycle();
    chk("err1_sticky", {255'd0, err1}, 256'd1);
    chk("err0_quiet",  {255'd0, err0}, '0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      reg_write = 1'($urandom_range(0, 1));
      rw        = 2'($urandom_range(0, 3));
      ra        = 2'($urandom_range(0, 3));
      rb        = 2'($urandom_range(0, 3));
      wmask     = 8'($urandom);
      bus_w     = rnd256();
      clear_req = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
